// File: rtl/bram_unloader.sv
// +----------------------------------------------------------------------------+
// | bram_unloader: reads num_words BRAM words and streams them as OBITS beats. |
// | Optional macro UNLOAD_MSB_FIRST_EN emits beats most-significant first.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_unloader #(
  parameter int ABITS = 8,
  parameter int DBITS = 512,
  parameter int OBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS-1:0] num_words,
  output logic [ABITS-1:0] rd_addr,
  input  logic [DBITS-1:0] rd_data,
  output logic [OBITS-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int BEATS = DBITS / OBITS;
  localparam int CBITS = $clog2(BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CAPT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ABITS-1:0]   rd_addr_q, rd_addr_d;
  logic [ABITS-1:0]   words_left_q, words_left_d;
  logic [CBITS-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DBITS-1:0]   shreg_q, shreg_d;
  logic [DBITS-1:0]   shreg_next;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

`ifdef UNLOAD_MSB_FIRST_EN
  assign shreg_next = shreg_q << OBITS;
  assign out_data   = shreg_q[DBITS-1 -: OBITS];
`else
  assign shreg_next = shreg_q >> OBITS;
  assign out_data   = shreg_q[OBITS-1:0];
`endif

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    words_left_d = words_left_q;
    beat_cnt_d   = beat_cnt_q;
    shreg_d      = shreg_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (num_words != '0) begin
            rd_addr_d    = base_addr;
            words_left_d = num_words;
            state_d      = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        shreg_d     = rd_data;
        beat_cnt_d  = CBITS'(BEATS);
        out_valid_d = 1'b1;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        if (out_valid_q && out_ready) begin
          shreg_d    = shreg_next;
          beat_cnt_d = beat_cnt_q - CBITS'(1);
          if (beat_cnt_q == CBITS'(1)) begin
            out_valid_d  = 1'b0;
            words_left_d = words_left_q - ABITS'(1);
            // Address wraps silently modulo 2^ABITS.
            if (words_left_q != ABITS'(1)) begin
              rd_addr_d = rd_addr_q + ABITS'(1);
              state_d   = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      words_left_q <= '0;
      beat_cnt_q   <= '0;
      shreg_q      <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      words_left_q <= words_left_d;
      beat_cnt_q   <= beat_cnt_d;
      shreg_q      <= shreg_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (beat_cnt_q == CBITS'(1)) && (words_left_q == ABITS'(1));
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_unloader.sv
// +----------------------------------------------------------------------------+
// | tb_bram_unloader: randomized scoreboard bench for bram_unloader.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_unloader;

  localparam int ABITS = 8;
  localparam int DBITS = 512;
  localparam int OBITS = 32;
  localparam int BEATS = DBITS / OBITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ABITS-1:0] base_addr = '0;
  logic [ABITS-1:0] num_words = '0;
  logic [ABITS-1:0] rd_addr;
  logic [DBITS-1:0] rd_data = '0;
  logic [OBITS-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             busy;
  logic             done;

  bram_unloader #(.ABITS(ABITS), .DBITS(DBITS), .OBITS(OBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [DBITS-1:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OBITS-1:0] exp_data[$];
  logic             exp_last[$];
  int  valid_due = -1;
  int  done_due = -1;
  int  xfers = 0;
  int  beat_in_word = 0;
  bit  done_seen = 0;
  int  rdy_mode = 0;

  logic             prev_valid = 0, prev_ready = 0, prev_last = 0, prev_rst = 0;
  logic [OBITS-1:0] prev_data = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom % 4) != 0;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    logic [OBITS-1:0] ed;
    logic             el;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        chk("valid_rise_cycle", cyc, valid_due);
        valid_due = -1;
      end
      if (prev_rst && prev_valid && !prev_ready && out_valid) begin
        chk("stall_hold_data", out_data, prev_data);
        chk("stall_hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          chk("beat_data", out_data, ed);
          chk("beat_last", out_last, el);
          chk("busy_during_beat", busy, 1);
          xfers++;
          beat_in_word++;
          if (el) done_due = cyc + 2;
          else if (beat_in_word == BEATS) valid_due = cyc + 3;
          if (beat_in_word == BEATS) beat_in_word = 0;
        end
      end
      if (done) begin
        chk("done_cycle", cyc, done_due);
        chk("busy_at_done", busy, 0);
        done_due = -1;
        done_seen = 1;
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_rst   = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected beat stream derived from memory contents.
  task automatic do_start(input int b, input int n);
    logic [DBITS-1:0] w;
    int idx;
    for (int wi = 0; wi < n; wi++) begin
      w = mem[(b + wi) % 256];
      for (int bt = 0; bt < BEATS; bt++) begin
`ifdef UNLOAD_MSB_FIRST_EN
        idx = BEATS - 1 - bt;
`else
        idx = bt;
`endif
        exp_data.push_back(w[idx*OBITS +: OBITS]);
        exp_last.push_back((wi == n - 1) && (bt == BEATS - 1));
      end
    end
    xfers = 0;
    beat_in_word = 0;
    done_seen = 0;
    if (n == 0) done_due = cyc + 2;
    else valid_due = cyc + 3;
    base_addr = ABITS'(b);
    num_words = ABITS'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = ABITS'($urandom);
    num_words = ABITS'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 5000; k++) begin
      if (done_seen) break;
      tick();
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    chk("beats_remaining", exp_data.size(), 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic wait_xfers(input int n);
    for (int k = 0; k < 300; k++) begin
      if (xfers >= n) break;
      tick();
    end
    chk("reached_beat", xfers, n);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < BEATS; k++)
        mem[a][k*OBITS +: OBITS] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_random();
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Two words, LSB word of 435 then all-zero word.
    rdy_mode = 0;
    mem[0] = 512'd435;
    mem[1] = '0;
    do_start(0, 2);
    wait_done();

    // Stall at beat 5 for three cycles.
    mem[0] = 512'd571;
    rdy_mode = 2;
    out_ready = 1'b1;
    do_start(0, 1);
    wait_xfers(5);
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_done();
    rdy_mode = 0;

    // Zero-length request.
    do_start(7, 0);
    wait_done();

    // Address wrap-around.
    do_start(255, 2);
    wait_done();

    // Reset during beat 7 of word 0, then a fresh unload.
    rdy_mode = 2;
    out_ready = 1'b1;
    do_start(4, 2);
    wait_xfers(7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_data.delete();
    exp_last.delete();
    valid_due = -1;
    done_due = -1;
    check_idle_outputs("midreset");
    done_seen = 0;
    repeat (10) tick();
    chk("no_done_after_reset", done_seen, 0);
    rdy_mode = 0;
    do_start(2, 1);
    wait_done();

    // Start re-asserted while busy.
    rdy_mode = 1;
    do_start(20, 2);
    repeat (5) tick();
    base_addr = 8'd9;
    num_words = 8'd3;
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    wait_done();

    // Randomized unloads with random back-pressure.
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) fill_random();
      do_start($urandom % 256, $urandom % 4);
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_unloader.md
BRAM_UNLOADER -- requirements
Module: bram_unloader

Interface
REQ-001 Parameter ABITS, default 8, BRAM address width.
REQ-002 Parameter DBITS, default 512, BRAM word width.
REQ-003 Parameter OBITS, default 32, output beat width; DBITS SHALL be an integer multiple of OBITS.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request an unload; sampled only in IDLE.
REQ-007 base_addr  input  ABITS  first BRAM word address; latched on accepted start.
REQ-008 num_words  input  ABITS  number of BRAM words to unload; latched on accepted start.
REQ-009 rd_addr  output  ABITS  BRAM read address, registered.
REQ-010 rd_data  input  DBITS  BRAM read data, valid one cycle after rd_addr.
REQ-011 out_data  output  OBITS  output beat.
REQ-012 out_valid  output  1  beat valid.
REQ-013 out_ready  input  1  consumer accepts beat.
REQ-014 out_last  output  1  final beat of the unload, qualified by out_valid.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last beat transfers.

Function
REQ-017 FSM states: IDLE, ADDR, CAPT, SHIFT, DONE.
REQ-018 IDLE: start=1 with num_words!=0 -> ADDR and rd_addr<=base_addr; start=1 with num_words=0 -> DONE with no beats; busy<=1 on either.
REQ-019 ADDR: wait one cycle for BRAM latency -> CAPT.
REQ-020 CAPT: load rd_data into a DBITS shift register, set beat counter to DBITS/OBITS, out_valid<=1 -> SHIFT.
REQ-021 SHIFT: out_data = low OBITS of shift register; on out_valid&&out_ready, shift right by OBITS and decrement the beat counter.
REQ-022 Transfer of the final beat of a word: if words remain, rd_addr<=rd_addr+1, out_valid<=0 -> ADDR; otherwise out_valid<=0 -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy<=0 -> IDLE.
REQ-024 First out_valid SHALL be high 3 cycles after the start-accept edge; each word adds 2 bubble cycles between words.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-026 out_last=1 only on the final beat of the final word.
REQ-027 rd_addr increments modulo 2^ABITS, so address wrap-around is silent.
REQ-028 start while busy is ignored; base_addr and num_words changes after acceptance have no effect.

Reset
REQ-029 rst_n=0 at a posedge SHALL force IDLE, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, counters=0, from any state, including mid-unload.
REQ-030 Reset mid-unload discards remaining beats and does not pulse done.

Configuration
REQ-031 Macro UNLOAD_MSB_FIRST_EN.
- Defined: beats within a word are emitted most-significant first (shift left, out_data = top OBITS).
- Undefined: beats are emitted LSB first as in REQ-021.
- Word order is ascending address in both cases.

Verification
REQ-032 BRAM[0]=435, BRAM[1]=0, base=0, num=2, out_ready=1 -> 32 beats. Beat0=435, beats1-31=0, out_last on beat31, done one cycle later, rd_addr sequence 0,1.
REQ-033 BRAM[0]=571, num=1, out_ready low for 3 cycles at beat 5 -> beat 5 holds and the beat count stays 16 with no loss or duplication. Under UNLOAD_MSB_FIRST_EN, beat15=571 instead of beat0.
REQ-034 num_words=0, start=1 -> no out_valid, done pulses on the 2nd cycle after accept, busy drops with it.
REQ-035 base=255, num=2 -> reads address 255 then 0, 32 beats, last on beat 31.
REQ-036 rst_n=0 for one cycle during beat 7 of word 0 -> all outputs 0 next cycle, no done. A new start (base=2, num=1) then unloads BRAM[2] normally.
REQ-037 start re-asserted with base=9 while busy -> ignored; the original unload completes unchanged.
